// File: rtl/truth_table_scanner.sv
// Stimulus/capture engine: walks {A,B,C,D} through 0..15, samples f_in after
// SETTLE cycles per vector, then compares the captured truth table to a latched mask.
module truth_table_scanner #(
    parameter int SETTLE = 1  // cycles per vector before sampling, 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        f_in,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic        match,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_mismatch
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESULT} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_exp;
    logic [3:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [3:0]  r_stim;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_table;
    logic        r_match;
    logic [4:0]  r_mcnt;
    logic [3:0]  r_first;

    logic        w_accept;
    logic        w_sample;
    logic [15:0] w_diff;
    logic [4:0]  w_mcnt;
    logic [3:0]  w_first;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_sample = (r_state == S_SCAN) && (r_cnt == 4'd0);
    assign w_diff   = r_table ^ r_exp;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_SCAN;
            S_SCAN:   if (w_sample && r_idx == 4'd15) w_next_state = S_RESULT;
            S_RESULT: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Popcount and lowest-set-bit encoder over the difference vector.
    always_comb begin
        w_mcnt  = 5'd0;
        w_first = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_diff[i]) w_mcnt = w_mcnt + 5'd1;
        end
        for (int i = 15; i >= 0; i--) begin
            if (w_diff[i]) w_first = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp   <= 16'd0;
            r_idx   <= 4'd0;
            r_cnt   <= 4'd0;
            r_stim  <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= 16'd0;
            r_match <= 1'b0;
            r_mcnt  <= 5'd0;
            r_first <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_exp   <= expected;
                        r_idx   <= 4'd0;
                        r_stim  <= 4'd0;
                        r_table <= 16'd0;
                        r_cnt   <= 4'(SETTLE - 1);
                        r_busy  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_table[r_idx] <= f_in;
                        // The last vector stays on the pins until RESULT clears them.
                        if (r_idx != 4'd15) begin
                            r_idx  <= r_idx + 4'd1;
                            r_stim <= r_idx + 4'd1;
                            r_cnt  <= 4'(SETTLE - 1);
                        end
                    end
                end
                S_RESULT: begin
                    r_match <= (w_diff == 16'd0);
                    r_mcnt  <= w_mcnt;
                    r_first <= w_first;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_stim  <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    assign {A, B, C, D}   = r_stim;
    assign busy           = r_busy;
    assign done           = r_done;
    assign truth_table    = r_table;
    assign match          = r_match;
    assign mismatch_cnt   = r_mcnt;
    assign first_mismatch = r_first;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: table of scan vectors plus hand
// sequences for ignored start, back-to-back start, reset abort and SETTLE=3.
module tb_truth_table_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start1, start3;
    logic [15:0] exp1, exp3;
    logic        f1, f3;
    logic [1:0]  mode;  // 0 model, 1 tied 0, 2 tied 1, 3 delayed model

    logic        a1, b1, c1, d1, busy1, done1, match1;
    logic [15:0] tt1;
    logic [4:0]  mc1;
    logic [3:0]  fm1;
    logic        a3, b3, c3, d3, busy3, done3, match3;
    logic [15:0] tt3;
    logic [4:0]  mc3;
    logic [3:0]  fm3;
    logic [3:0]  stim1, stim3;
    logic [1:0]  p1 = 2'b00;
    logic [1:0]  p3 = 2'b00;

    int checks = 0;
    int failures = 0;

    assign stim1 = {a1, b1, c1, d1};
    assign stim3 = {a3, b3, c3, d3};

    function automatic logic f_model(input logic [3:0] v);
        return (v[2] & v[1]) | (v[1] & v[0]) | (v[3] & v[2] & v[0]);
    endfunction

    always @(posedge clk) begin
        p1 <= {p1[0], f_model(stim1)};
        p3 <= {p3[0], f_model(stim3)};
    end

    always_comb begin
        f1 = 1'b0;
        case (mode)
            2'd0: f1 = f_model(stim1);
            2'd1: f1 = 1'b0;
            2'd2: f1 = 1'b1;
            default: f1 = p1[1];
        endcase
    end
    assign f3 = p3[1];

    truth_table_scanner #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(exp1), .f_in(f1),
        .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1),
        .truth_table(tt1), .match(match1), .mismatch_cnt(mc1), .first_mismatch(fm1)
    );

    truth_table_scanner #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .expected(exp3), .f_in(f3),
        .A(a3), .B(b3), .C(c3), .D(d3), .busy(busy3), .done(done3),
        .truth_table(tt3), .match(match3), .mismatch_cnt(mc3), .first_mismatch(fm3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Start a SETTLE=1 scan and wait for done; lat = cycles from start edge to done.
    task automatic run1(input logic [15:0] e, output int lat);
        int cyc;
        exp1 = e;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 0;
        chk("busy_after_start", busy1, 1);
        chk("stim_0", stim1, 0);
        while (!done1 && cyc < 200) begin
            tick();
            cyc++;
            if (cyc <= 15) chk("stim_step", stim1, cyc);
        end
        lat = cyc;
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] e;
        logic [15:0] tbl;
        logic        m;
        logic [4:0]  cnt;
        logic [3:0]  first;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        int cyc;
        logic seen;

        vecs[0] = '{2'd0, 16'hE8C8, 16'hE8C8, 1'b1, 5'd0,  4'd0};
        vecs[1] = '{2'd0, 16'hE8C9, 16'hE8C8, 1'b0, 5'd1,  4'd0};
        vecs[2] = '{2'd0, 16'hE8C0, 16'hE8C8, 1'b0, 5'd1,  4'd3};
        vecs[3] = '{2'd1, 16'hFFFF, 16'h0000, 1'b0, 5'd16, 4'd0};
        vecs[4] = '{2'd2, 16'hFFFF, 16'hFFFF, 1'b1, 5'd0,  4'd0};
        vecs[5] = '{2'd2, 16'h0F0F, 16'hFFFF, 1'b0, 5'd8,  4'd4};

        rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
        exp1 = 16'h0; exp3 = 16'h0; mode = 2'd0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_dut1", {stim1, busy1, done1, match1, tt1, mc1, fm1}, 0);
        chk("reset_dut3", {stim3, busy3, done3, match3, tt3, mc3, fm3}, 0);

        foreach (vecs[i]) begin
            mode = vecs[i].mode;
            run1(vecs[i].e, lat);
            chk("latency", lat, 17);
            chk("done", done1, 1);
            chk("busy_at_done", busy1, 0);
            chk("table", tt1, vecs[i].tbl);
            chk("match", match1, vecs[i].m);
            chk("mismatch_cnt", mc1, vecs[i].cnt);
            chk("first_mismatch", fm1, vecs[i].first);
            tick();
            chk("done_one_cycle", done1, 0);
            chk("table_hold", tt1, vecs[i].tbl);
        end

        // Start re-pulsed with a new mask mid-scan must be ignored.
        mode = 2'd0;
        exp1 = 16'hE8C8;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 200) begin
            tick();
            cyc++;
            if (cyc == 5) begin start1 = 1'b1; exp1 = 16'h0000; end
            else start1 = 1'b0;
        end
        chk("ign_latency", cyc, 17);
        chk("ign_table", tt1, 16'hE8C8);
        chk("ign_match", match1, 1);
        chk("ign_cnt", mc1, 0);

        // Start in the done cycle is accepted.
        exp1 = 16'hE8C8;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("b2b_busy", busy1, 1);
        chk("b2b_done_low", done1, 0);
        cyc = 0;
        while (!done1 && cyc < 200) begin tick(); cyc++; end
        chk("b2b_latency", cyc, 17);
        chk("b2b_match", match1, 1);

        // Reset mid-scan aborts with everything cleared and no done.
        exp1 = 16'hE8C8;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_abort_outputs", {stim1, busy1, done1, match1, tt1, mc1, fm1}, 0);
        seen = 1'b0;
        repeat (20) begin tick(); if (done1) seen = 1'b1; end
        chk("rst_no_done", seen, 0);
        run1(16'hE8C8, lat);
        chk("rst_rescan_latency", lat, 17);
        chk("rst_rescan_table", tt1, 16'hE8C8);
        chk("rst_rescan_match", match1, 1);

        // SETTLE=3 with a two-stage delayed function.
        exp3 = 16'hE8C8;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        cyc = 0;
        while (!done3 && cyc < 400) begin
            tick();
            cyc++;
            if (cyc == 2) chk("s3_stim_hold", stim3, 0);
            if (cyc == 3) chk("s3_stim_1", stim3, 1);
            if (cyc == 6) chk("s3_stim_2", stim3, 2);
        end
        chk("s3_latency", cyc, 49);
        chk("s3_table", tt3, 16'hE8C8);
        chk("s3_match", match3, 1);
        chk("s3_cnt", mc3, 0);

        // Same delayed function with SETTLE=1 samples too early.
        mode = 2'd3;
        run1(16'hE8C8, lat);
        chk("s1_delayed_latency", lat, 17);
        chk("s1_delayed_match", match1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus/capture engine for 4-input Boolean function blocks.
- Drives A,B,C,D through all 16 combinations and samples the block's output `f` after a settle delay.
- Builds the 16-bit minterm truth table and compares it against a latched expected mask.
- Sits on the drive side of the combinational P01 gate networks; used for on-board self-check of SOP/POS/NAND/NOR realisations.

Parameters:
- SETTLE, 1, clock cycles each input vector is held before `f_in` is sampled; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a scan; accepted only when busy=0.
- expected  in  16  expected truth table, bit i = f for {A,B,C,D}=i (A is the MSB); latched on an accepted start.
- f_in  in  1  output of the function under test.
- A  out  1  stimulus bit 3.
- B  out  1  stimulus bit 2.
- C  out  1  stimulus bit 1.
- D  out  1  stimulus bit 0.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when the result is valid.
- table  out  16  captured truth table.
- match  out  1  table == latched expected.
- mismatch_cnt  out  5  popcount(table ^ expected), range 0..16.
- first_mismatch  out  4  lowest differing index; 0 if none.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - A..D, busy, done, table, match, mismatch_cnt, first_mismatch, index, settle counter, latched expected all 0.
  - Reset has priority over start; a reset mid-scan aborts the scan with no done pulse.
- States: IDLE, SCAN, RESULT.
- IDLE, start=1 at edge E0:
  - exp_q<=expected; idx<=0; {A,B,C,D}<=0; table<=0.
  - cnt<=SETTLE-1; busy<=1; state<=SCAN.
  - match, mismatch_cnt and first_mismatch are NOT cleared until RESULT.
- SCAN:
  - {A,B,C,D} always equals idx (registered).
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: table[idx]<=f_in.
    - If idx==15: state<=RESULT.
    - Else: idx<=idx+1 and cnt<=SETTLE-1.
  - Sample k is taken at edge E0+(k+1)*SETTLE; f_in gets exactly SETTLE cycles of settling per vector.
- RESULT (one cycle, entered after edge E0+16*SETTLE):
  - At the following edge: match, mismatch_cnt and first_mismatch are computed from the complete table vs exp_q and registered.
  - At the same edge: done<=1, busy<=0, state<=IDLE, A..D<=0.
  - done is high for exactly one cycle, at E0+16*SETTLE+1.
- Hold and restart:
  - Results and table hold until the next accepted start.
  - A start during the done cycle is accepted normally (busy=0).
  - start while busy=1 is ignored; no queuing.
  - Changes to `expected` during a scan are ignored.
- Width rules:
  - mismatch_cnt is 5 bits so that 16 fits.
  - first_mismatch is a priority encoder from bit 0 upward.
- Latency: start to done = 16*SETTLE+1 cycles.

Test Plan:
- SETTLE=1, bench models f = B·C | C·D | A·B·D, expected=16'hE8C8, start 1 cycle -> A..D step 0..15 one per cycle; done at start+17; table=16'hE8C8, match=1, mismatch_cnt=0, first_mismatch=0.
- Same model, expected=16'hE8C9 -> match=0, mismatch_cnt=1, first_mismatch=0; expected=16'hE8C0 -> mismatch_cnt=1, first_mismatch=3.
- f_in tied 0, expected=16'hFFFF -> table=0, mismatch_cnt=16 (5'b10000), first_mismatch=0, match=0; f_in tied 1, expected=16'hFFFF -> match=1.
- Start accepted, then start re-pulsed and expected changed to 16'h0000 at cycle 5 -> ignored; done still at start+17, result uses 16'hE8C8; start asserted in the done cycle begins a second scan with busy=1 next cycle.
- rst asserted at cycle 8 of a scan -> next edge: all outputs 0, no done pulse; a subsequent start yields a full 16-vector scan with correct results.
- SETTLE=3, bench f delayed by a 2-stage register pipeline -> each vector held 3 cycles; table=16'hE8C8, done at start+49; with SETTLE=1 the same bench gives match=0.
